// File: rtl/ccu_dac_writer_if.sv
// ccu_dac_writer_if: payload AXI4-Stream byte input plus AXI4 write port to the DAC.
// master = the writer (drives tready, aw*, w*, bready); slave = upstream/downstream environment.
interface ccu_dac_writer_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        pay_axis_tdata;
  logic              pay_axis_tvalid;
  logic              pay_axis_tready;
  logic              pay_axis_tlast;
  logic [ADDR_W-1:0] dac_axi_awaddr;
  logic              dac_axi_awvalid;
  logic              dac_axi_awready;
  logic [7:0]        dac_axi_wdata;
  logic              dac_axi_wvalid;
  logic              dac_axi_wready;
  logic              dac_axi_wlast;
  logic [1:0]        dac_axi_bresp;
  logic              dac_axi_bvalid;
  logic              dac_axi_bready;

  modport master (
    input  pay_axis_tdata, pay_axis_tvalid, pay_axis_tlast,
    output pay_axis_tready,
    output dac_axi_awaddr, dac_axi_awvalid,
    input  dac_axi_awready,
    output dac_axi_wdata, dac_axi_wvalid, dac_axi_wlast,
    input  dac_axi_wready,
    input  dac_axi_bresp, dac_axi_bvalid,
    output dac_axi_bready
  );

  modport slave (
    output pay_axis_tdata, pay_axis_tvalid, pay_axis_tlast,
    input  pay_axis_tready,
    input  dac_axi_awaddr, dac_axi_awvalid,
    output dac_axi_awready,
    input  dac_axi_wdata, dac_axi_wvalid, dac_axi_wlast,
    output dac_axi_wready,
    output dac_axi_bresp, dac_axi_bvalid,
    input  dac_axi_bready
  );
endinterface

// File: rtl/ccu_dac_writer.sv
// ccu_dac_writer: turns a DATA_DAC payload (2 addr bytes MSB first + data) into AXI4
// write bursts of at most MAX_BURST bytes. Ports: axi_aclk, axi_aresetn, bus (master
// modport: pay_axis_* in, dac_axi_* out), busy/done/err status. Optional macro
// CCU_DAC_RESP_CHECK_EN: a bad bresp sets err and drains the rest of the packet.
module ccu_dac_writer #(
  parameter int MAX_BURST = 16,
  parameter int ADDR_W    = 16
) (
  input  logic            axi_aclk,
  input  logic            axi_aresetn,
  ccu_dac_writer_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_AW,
    S_W,
    S_B,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic              run_q, run_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              eop_q, eop_d;
  logic              err_q, err_d;
  logic              wlast_c;

  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    hi_d    = hi_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    eop_d   = eop_q;
    err_d   = err_q;
    wlast_c = 1'b0;

    bus.pay_axis_tready = 1'b0;
    bus.dac_axi_awvalid = 1'b0;
    bus.dac_axi_wvalid  = 1'b0;
    bus.dac_axi_wdata   = 8'h00;
    bus.dac_axi_bready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // run_q keeps tready low through reset and the cycle after it
        bus.pay_axis_tready = run_q;
        if (run_q && bus.pay_axis_tvalid) begin
          hi_d  = bus.pay_axis_tdata;
          err_d = bus.pay_axis_tlast;
          state_d = bus.pay_axis_tlast ? S_DONE : S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        bus.pay_axis_tready = 1'b1;
        if (bus.pay_axis_tvalid) begin
          addr_d = ADDR_W'({hi_q, bus.pay_axis_tdata});
          if (bus.pay_axis_tlast) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_AW;
          end
        end
      end
      S_AW: begin
        bus.dac_axi_awvalid = 1'b1;
        if (bus.dac_axi_awready) begin
          cnt_d   = '0;
          state_d = S_W;
        end
      end
      S_W: begin
        // payload passes straight through to the W channel
        wlast_c = bus.pay_axis_tlast | (cnt_q == CNT_LAST);
        bus.dac_axi_wvalid  = bus.pay_axis_tvalid;
        bus.dac_axi_wdata   = bus.pay_axis_tdata;
        bus.pay_axis_tready = bus.dac_axi_wready;
        if (bus.pay_axis_tvalid && bus.dac_axi_wready) begin
          cnt_d  = cnt_q + CNT_W'(1);
          addr_d = addr_q + ADDR_W'(1);
          if (wlast_c) begin
            eop_d   = bus.pay_axis_tlast;
            state_d = S_B;
          end
        end
      end
      S_B: begin
        bus.dac_axi_bready = 1'b1;
        if (bus.dac_axi_bvalid) begin
`ifdef CCU_DAC_RESP_CHECK_EN
          if (bus.dac_axi_bresp != 2'b00) begin
            err_d   = 1'b1;
            state_d = eop_q ? S_DONE : S_DRAIN;
          end else begin
            state_d = eop_q ? S_DONE : S_AW;
          end
`else
          state_d = eop_q ? S_DONE : S_AW;
`endif
        end
      end
      S_DRAIN: begin
        bus.pay_axis_tready = 1'b1;
        if (bus.pay_axis_tvalid && bus.pay_axis_tlast)
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    bus.dac_axi_wlast = wlast_c;
  end

  assign bus.dac_axi_awaddr = addr_q;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      hi_q    <= 8'h00;
      addr_q  <= '0;
      cnt_q   <= '0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ccu_dac_writer.sv
// tb_ccu_dac_writer: directed packets into ccu_dac_writer with an AXI slave model,
// expected bursts built from the packet contents.
module tb_ccu_dac_writer;

  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, err;

  always #5 clk = ~clk;

  ccu_dac_writer_if #(.ADDR_W(16)) bus ();

  ccu_dac_writer #(
    .MAX_BURST(MB),
    .ADDR_W(16)
  ) dut (
    .axi_aclk   (clk),
    .axi_aresetn(rst_n),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [8:0]  src_q[$];
  logic [7:0]  dat_q[$];
  logic [15:0] aw_got[$];
  logic [8:0]  w_got[$];
  logic [15:0] exp_aw[$];
  logic [8:0]  exp_w[$];

  int stall = 0;
  int err_burst = -1;
  int b_owed, b_idx;
  int done_cnt, aw_moved, busy_at_done;
  logic aw_pend = 1'b0;
  logic [15:0] aw_hold = 16'h0;
  logic pay_hs = 1'b0;
  logic b_hs = 1'b0;

  task automatic step();
    @(negedge clk);
    if (pay_hs) void'(src_q.pop_front());
    if (!(bus.pay_axis_tvalid && !pay_hs))
      bus.pay_axis_tvalid = (src_q.size() > 0) &&
                            ($urandom_range(99) >= stall);
    if (src_q.size() > 0) begin
      bus.pay_axis_tlast = src_q[0][8];
      bus.pay_axis_tdata = src_q[0][7:0];
    end else begin
      bus.pay_axis_tlast = 1'b0;
      bus.pay_axis_tdata = 8'h00;
    end
    bus.dac_axi_awready = ($urandom_range(99) >= stall);
    bus.dac_axi_wready  = ($urandom_range(99) >= stall);
    if (b_hs) bus.dac_axi_bvalid = 1'b0;
    if (!bus.dac_axi_bvalid && b_owed > 0 &&
        $urandom_range(99) >= stall) begin
      bus.dac_axi_bvalid = 1'b1;
      bus.dac_axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
      b_owed--;
      b_idx++;
    end
    #1;
    pay_hs = bus.pay_axis_tvalid && bus.pay_axis_tready;
    b_hs   = bus.dac_axi_bvalid && bus.dac_axi_bready;
    if (bus.dac_axi_awvalid && bus.dac_axi_awready)
      aw_got.push_back(bus.dac_axi_awaddr);
    if (bus.dac_axi_wvalid && bus.dac_axi_wready) begin
      w_got.push_back({bus.dac_axi_wlast, bus.dac_axi_wdata});
      if (bus.dac_axi_wlast) b_owed++;
    end
    if (aw_pend && bus.dac_axi_awaddr !== aw_hold) aw_moved++;
    aw_pend = bus.dac_axi_awvalid && !bus.dac_axi_awready;
    aw_hold = bus.dac_axi_awaddr;
    if (done) begin
      done_cnt++;
      if (busy) busy_at_done++;
    end
  endtask

  task automatic mk_pkt(input logic [15:0] a, input int n, input bit rnd);
    logic [7:0] d;
    src_q.delete();
    dat_q.delete();
    src_q.push_back({1'b0, a[15:8]});
    src_q.push_back({(n == 0), a[7:0]});
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom) : 8'(8'hAA + 8'h11 * i);
      src_q.push_back({(i == n - 1), d});
      dat_q.push_back(d);
    end
  endtask

  task automatic model(input logic [15:0] a, input int n, input int stop);
    int rem, len, k, idx;
    logic [15:0] p;
    exp_aw.delete();
    exp_w.delete();
    rem = n;
    k = 0;
    idx = 0;
    p = a;
    while (rem > 0 && (stop < 0 || k <= stop)) begin
      len = (rem > MB) ? MB : rem;
      exp_aw.push_back(p);
      for (int j = 0; j < len; j++) begin
        exp_w.push_back({(j == len - 1), dat_q[idx]});
        idx++;
      end
      p = p + 16'(len);
      rem -= len;
      k++;
    end
  endtask

  task automatic run_pkt(input string tag, input int budget);
    int cyc;
    cyc = 0;
    aw_got.delete();
    w_got.delete();
    done_cnt = 0;
    aw_moved = 0;
    busy_at_done = 0;
    b_owed = 0;
    b_idx = 0;
    while (done_cnt == 0 && cyc < budget) begin
      step();
      cyc++;
    end
    chk({tag, " finished"}, (done_cnt != 0), 1);
    repeat (3) step();
  endtask

  task automatic verify(input string tag, input logic exp_err);
    int bad;
    chk({tag, " aw count"}, aw_got.size(), exp_aw.size());
    bad = 0;
    for (int i = 0; i < aw_got.size() && i < exp_aw.size(); i++)
      if (aw_got[i] !== exp_aw[i]) bad++;
    chk({tag, " aw addr bad"}, bad, 0);
    chk({tag, " w count"}, w_got.size(), exp_w.size());
    bad = 0;
    for (int i = 0; i < w_got.size() && i < exp_w.size(); i++)
      if (w_got[i] !== exp_w[i]) bad++;
    chk({tag, " wdata/wlast bad"}, bad, 0);
    chk({tag, " done pulses"}, done_cnt, 1);
    chk({tag, " busy at done"}, busy_at_done, 1);
    chk({tag, " busy after"}, busy, 0);
    chk({tag, " err"}, err, exp_err);
    chk({tag, " awaddr moved"}, aw_moved, 0);
  endtask

  function automatic logic [7:0] out_bits();
    return {bus.pay_axis_tready, bus.dac_axi_awvalid, bus.dac_axi_wvalid,
            bus.dac_axi_wlast, bus.dac_axi_bready, busy, done, err};
  endfunction

  int stop_b;
  logic exp_e6;

  initial begin
    bus.pay_axis_tdata  = 8'h00;
    bus.pay_axis_tvalid = 1'b0;
    bus.pay_axis_tlast  = 1'b0;
    bus.dac_axi_awready = 1'b0;
    bus.dac_axi_wready  = 1'b0;
    bus.dac_axi_bresp   = 2'b00;
    bus.dac_axi_bvalid  = 1'b0;

    #2;
    chk("reset outputs", out_bits(), 8'h00);
    chk("reset awaddr", bus.dac_axi_awaddr, 16'h0000);
    chk("reset wdata", bus.dac_axi_wdata, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    mk_pkt(16'h1234, 3, 1'b0);
    model(16'h1234, 3, -1);
    run_pkt("t1", 500);
    verify("t1", 1'b0);

    mk_pkt(16'h00F8, 20, 1'b0);
    model(16'h00F8, 20, -1);
    run_pkt("t2", 500);
    verify("t2", 1'b0);
    chk("t2 end addr", bus.dac_axi_awaddr, 16'h010C);

    mk_pkt(16'hFFFE, 4, 1'b1);
    model(16'hFFFE, 4, -1);
    run_pkt("t3", 500);
    verify("t3", 1'b0);
    chk("t3 wrapped addr", bus.dac_axi_awaddr, 16'h0002);

    src_q.delete();
    dat_q.delete();
    src_q.push_back({1'b1, 8'h12});
    model(16'h0000, 0, -1);
    run_pkt("t4a", 200);
    verify("t4a", 1'b1);

    mk_pkt(16'h1234, 0, 1'b0);
    model(16'h1234, 0, -1);
    run_pkt("t4b", 200);
    verify("t4b", 1'b1);

    mk_pkt(16'h0420, 5, 1'b1);
    model(16'h0420, 5, -1);
    run_pkt("t4c", 500);
    verify("t4c", 1'b0);

    stall = 50;
    mk_pkt(16'h3000, 1000, 1'b1);
    model(16'h3000, 1000, -1);
    run_pkt("t5", 40000);
    verify("t5", 1'b0);
    stall = 0;

`ifdef CCU_DAC_RESP_CHECK_EN
    stop_b = 0;
    exp_e6 = 1'b1;
`else
    stop_b = -1;
    exp_e6 = 1'b0;
`endif
    err_burst = 0;
    mk_pkt(16'h5000, 40, 1'b1);
    model(16'h5000, 40, stop_b);
    run_pkt("t6", 2000);
    verify("t6", exp_e6);
    err_burst = -1;

    mk_pkt(16'h4000, 10, 1'b0);
    aw_got.delete();
    w_got.delete();
    b_owed = 0;
    b_idx = 0;
    for (int c = 0; c < 200 && w_got.size() < 3; c++) step();
    chk("t7 reached W", (w_got.size() >= 3), 1);
    chk("t7 wvalid before reset", bus.dac_axi_wvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t7 outputs in reset", out_bits(), 8'h00);
    chk("t7 awaddr in reset", bus.dac_axi_awaddr, 16'h0000);
    src_q.delete();
    bus.pay_axis_tvalid = 1'b0;
    bus.pay_axis_tlast  = 1'b0;
    bus.dac_axi_bvalid  = 1'b0;
    pay_hs = 1'b0;
    b_hs = 1'b0;
    aw_pend = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    mk_pkt(16'h0A0B, 17, 1'b1);
    model(16'h0A0B, 17, -1);
    run_pkt("t8", 1000);
    verify("t8", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
